// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 VGA path, the sync-monitor
//   FSM state type, the coordinate width, and a saturating increment helper.
//   The constants are the defaults for the monitor's geometry parameters.
package vga_timing_pkg;

  localparam int COORD_W = 11;

  // 640x480@60 geometry, pixel ticks horizontally and lines vertically.
  localparam int H_ACTIVE = 640;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = 525;

  // Asserted level of HS/VS (0 = active-low).
  localparam logic SYNC_POL = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_e;

  // Counters stick at all-ones so a dead input never wraps into a
  // plausible-looking period.
  function automatic coord_t sat_inc(coord_t v);
    return (v == '1) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Samples one sync line on pixel ticks, folds in the polarity and produces
//   level/edge indications in "asserted" terms.
//   clk, rst      : clock, asynchronous active-high reset
//   pix_en        : pixel tick strobe; sampling happens only on these cycles
//   sync_in       : raw sync wire
//   act           : latest sample is asserted
//   rise          : latest sample asserted, previous one deasserted
//   fall          : latest sample deasserted, previous one asserted
module sync_edge_det #(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic sync_in,
  output logic act,
  output logic rise,
  output logic fall
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = cur_q;
    prev_d = prev_q;
    if (pix_en) begin
      prev_d = cur_q;
      cur_d  = (sync_in == SYNC_POL);
    end
  end

  // Both samples reset to "deasserted" so the first tick after reset
  // cannot report an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign act  = cur_q;
  assign rise = cur_q & ~prev_q;
  assign fall = ~cur_q & prev_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side VGA timing checker. Recovers pixel position from HS/VS,
//   measures line/frame geometry and reports lock and sticky error status.
//   CLK_100MHz : system clock
//   Reset      : asynchronous active-high reset
//   PixEn      : one-cycle pixel tick strobe; counting happens only here
//   HS, VS     : sync pair under test
//   ClearErr   : clears SyncErr (sampled every clock)
//   RecX/RecY  : recovered active coordinate, 0 outside the active region
//   RecActive  : locked and inside the active region
//   LineLen    : last HS-edge-to-HS-edge period in ticks
//   FrameLines : last VS-edge-to-VS-edge period in lines
//   HSWidth    : last HS asserted width in ticks
//   Locked     : geometry verified and tracking
//   SyncErr    : sticky timing violation seen while locked
module vga_sync_monitor #(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK   = vga_timing_pkg::H_BACK,
  parameter int   H_TOTAL  = vga_timing_pkg::H_TOTAL,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK   = vga_timing_pkg::V_BACK,
  parameter int   V_TOTAL  = vga_timing_pkg::V_TOTAL,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic        CLK_100MHz,
  input  logic        Reset,
  input  logic        PixEn,
  input  logic        HS,
  input  logic        VS,
  input  logic        ClearErr,
  output logic [10:0] RecX,
  output logic [10:0] RecY,
  output logic        RecActive,
  output logic [10:0] LineLen,
  output logic [10:0] FrameLines,
  output logic [10:0] HSWidth,
  output logic        Locked,
  output logic        SyncErr
);

  import vga_timing_pkg::*;

  localparam coord_t HT  = coord_t'(H_TOTAL);
  localparam coord_t VT  = coord_t'(V_TOTAL);
  localparam coord_t HSW = coord_t'(H_SYNC);
  localparam coord_t VSW = coord_t'(V_SYNC);
  localparam coord_t HX0 = coord_t'(H_SYNC + H_BACK);
  localparam coord_t HX1 = coord_t'(H_SYNC + H_BACK + H_ACTIVE);
  localparam coord_t VY0 = coord_t'(V_SYNC + V_BACK);
  localparam coord_t VY1 = coord_t'(V_SYNC + V_BACK + V_ACTIVE);

  // ---------------------------------------------------------------- syncs
  logic hs_act, hs_rise, hs_fall;
  logic vs_act, vs_rise, vs_fall;

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_det (
    .clk    (CLK_100MHz),
    .rst    (Reset),
    .pix_en (PixEn),
    .sync_in(HS),
    .act    (hs_act),
    .rise   (hs_rise),
    .fall   (hs_fall)
  );

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_det (
    .clk    (CLK_100MHz),
    .rst    (Reset),
    .pix_en (PixEn),
    .sync_in(VS),
    .act    (vs_act),
    .rise   (vs_rise),
    .fall   (vs_fall)
  );

  // ------------------------------------------------------------- counters
  coord_t hcnt_q, hcnt_d;
  coord_t vcnt_q, vcnt_d;
  coord_t hwcnt_q, hwcnt_d;
  coord_t vwcnt_q, vwcnt_d;
  coord_t vs_width_q, vs_width_d;
  coord_t line_len_q, line_len_d;
  coord_t frame_lines_q, frame_lines_d;
  coord_t hs_width_q, hs_width_d;
  coord_t rec_x_q, rec_x_d;
  coord_t rec_y_q, rec_y_d;
  logic   rec_active_q, rec_active_d;

  coord_t hcnt_inc, vcnt_inc;
  logic   in_h, in_v;

  state_e state_q, state_d;
  logic   locked_q, locked_d;
  logic   sync_err_q, sync_err_d;

  assign hcnt_inc = sat_inc(hcnt_q);
  assign vcnt_inc = sat_inc(vcnt_q);
  assign in_h     = (hcnt_q >= HX0) && (hcnt_q < HX1);
  assign in_v     = (vcnt_q >= VY0) && (vcnt_q < VY1);

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hwcnt_d       = hwcnt_q;
    vwcnt_d       = vwcnt_q;
    vs_width_d    = vs_width_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    hs_width_d    = hs_width_q;
    rec_x_d       = rec_x_q;
    rec_y_d       = rec_y_q;
    rec_active_d  = rec_active_q;
    if (PixEn) begin
      if (hs_rise) begin
        hcnt_d     = '0;
        line_len_d = hcnt_inc;
      end else begin
        hcnt_d = hcnt_inc;
      end

      if (hs_fall) begin
        hs_width_d = hwcnt_q;
        hwcnt_d    = '0;
      end else if (hs_act) begin
        hwcnt_d = sat_inc(hwcnt_q);
      end

      // A VS edge coinciding with an HS edge restarts the frame rather
      // than counting a line.
      if (vs_rise) begin
        vcnt_d        = '0;
        frame_lines_d = vcnt_inc;
      end else if (hs_rise) begin
        vcnt_d = vcnt_inc;
      end

      // VS width is measured in HS edges seen while VS is asserted.
      if (vs_fall) begin
        vs_width_d = vwcnt_q;
        vwcnt_d    = '0;
      end else if (vs_act && hs_rise) begin
        vwcnt_d = sat_inc(vwcnt_q);
      end

      // Position outputs trail the counters by one tick.
      rec_active_d = locked_q && in_h && in_v;
      rec_x_d      = rec_active_d ? hcnt_q - HX0 : '0;
      rec_y_d      = rec_active_d ? vcnt_q - VY0 : '0;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hwcnt_q       <= '0;
      vwcnt_q       <= '0;
      vs_width_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      hs_width_q    <= '0;
      rec_x_q       <= '0;
      rec_y_q       <= '0;
      rec_active_q  <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hwcnt_q       <= hwcnt_d;
      vwcnt_q       <= vwcnt_d;
      vs_width_q    <= vs_width_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      hs_width_q    <= hs_width_d;
      rec_x_q       <= rec_x_d;
      rec_y_q       <= rec_y_d;
      rec_active_q  <= rec_active_d;
    end
  end

  // ------------------------------------------------------------------ FSM
  logic geom_ok, violation;

  // At a VS edge the stored measurements describe the frame just ended.
  assign geom_ok = (line_len_q == HT) && (vcnt_inc == VT) &&
                   (hs_width_q == HSW) && (vs_width_q == VSW);

  // "hcnt reaching H_TOTAL" is the tick on which it would step to H_TOTAL
  // without an HS edge to restart the line.
  assign violation = PixEn && (state_q == LOCKED) &&
                     (( hs_rise && (hcnt_inc != HT)) ||
                      (!hs_rise && (hcnt_inc == HT)) ||
                      ( vs_rise && (vcnt_inc != VT)));

  always_comb begin
    state_d = state_q;
    if (PixEn) begin
      case (state_q)
        SEARCH:  if (vs_rise) state_d = MEASURE;
        MEASURE: if (vs_rise && geom_ok) state_d = LOCKED;
        LOCKED:  if (violation) state_d = MEASURE;
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
    // Set beats clear when both land in the same cycle.
    if (violation)     sync_err_d = 1'b1;
    else if (ClearErr) sync_err_d = 1'b0;
    else               sync_err_d = sync_err_q;
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      state_q    <= SEARCH;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign RecX       = rec_x_q;
  assign RecY       = rec_y_q;
  assign RecActive  = rec_active_q;
  assign LineLen    = line_len_q;
  assign FrameLines = frame_lines_q;
  assign HSWidth    = hs_width_q;
  assign Locked     = locked_q;
  assign SyncErr    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor
//   Directed bench for vga_sync_monitor on a scaled-down geometry
//   (28 ticks x 12 lines, HS 4 ticks, VS 2 lines) so whole frames fit in a
//   short run. A small generator emits the driver waveform one pixel tick
//   at a time; (lh, lv) is the position emitted on the last tick.
//   With the one-tick sampling latency, after emitting (h, v) with h >= 2:
//   hcnt = h-1, vcnt = v, and RecX/RecY/RecActive reflect hcnt = h-2.
module tb_vga_sync_monitor;

  localparam int H_S = 4, H_B = 3, H_A = 16, H_T = 28;
  localparam int V_S = 2, V_B = 2, V_A = 6,  V_T = 12;

  logic        clk = 1'b0;
  logic        rst, pix_en, hs, vs, clr_err;
  logic [10:0] rec_x, rec_y, line_len, frame_lines, hs_width;
  logic        rec_active, locked, sync_err;

  int n_chk = 0, n_fail = 0;
  int gh = 0, gv = 0, lh = -1, lv = -1;
  int cur_len = H_T, hs_w = H_S;
  bit hs_dead = 1'b0;

  vga_sync_monitor #(
    .H_ACTIVE(H_A), .H_SYNC(H_S), .H_BACK(H_B), .H_TOTAL(H_T),
    .V_ACTIVE(V_A), .V_SYNC(V_S), .V_BACK(V_B), .V_TOTAL(V_T),
    .SYNC_POL(1'b0)
  ) dut (
    .CLK_100MHz(clk),
    .Reset     (rst),
    .PixEn     (pix_en),
    .HS        (hs),
    .VS        (vs),
    .ClearErr  (clr_err),
    .RecX      (rec_x),
    .RecY      (rec_y),
    .RecActive (rec_active),
    .LineLen   (line_len),
    .FrameLines(frame_lines),
    .HSWidth   (hs_width),
    .Locked    (locked),
    .SyncErr   (sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One pixel tick: PixEn for one clock, then three idle clocks.
  // clr holds ClearErr only across the PixEn edge.
  task automatic tick(input bit clr);
    hs      = (!hs_dead && gh < hs_w) ? 1'b0 : 1'b1;
    vs      = (gv < V_S) ? 1'b0 : 1'b1;
    pix_en  = 1'b1;
    clr_err = clr;
    @(posedge clk); #1;
    pix_en  = 1'b0;
    clr_err = 1'b0;
    lh = gh;
    lv = gv;
    if (gh >= cur_len - 1) begin
      gh      = 0;
      cur_len = H_T;
      gv      = (gv == V_T - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(lh == h && lv == v) && n < 20000) begin
      tick(1'b0);
      n++;
    end
    if (!(lh == h && lv == v)) chk("run_to_timeout", 1, 0);
  endtask

  task automatic pulse_clear();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_recx"},   rec_x,       0);
    chk({tag, "_recy"},   rec_y,       0);
    chk({tag, "_recact"}, rec_active,  0);
    chk({tag, "_linelen"}, line_len,   0);
    chk({tag, "_frlines"}, frame_lines, 0);
    chk({tag, "_hswidth"}, hs_width,   0);
    chk({tag, "_locked"}, locked,      0);
    chk({tag, "_syncerr"}, sync_err,   0);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Nominal: first VS edge at emitted (1,0) -> MEASURE, second -> LOCKED.
    tick(1'b0);
    tick(1'b0);
    chk("lock_first_edge", locked, 0);
    run_to(0, 0);
    chk("lock_before_second", locked, 0);
    tick(1'b0);
    chk("lock_second_edge", locked, 1);
    chk("nom_linelen", line_len, H_T);
    chk("nom_frlines", frame_lines, V_T);
    chk("nom_hswidth", hs_width, H_S);
    chk("nom_syncerr", sync_err, 0);

    // Active-window boundaries: hcnt 7..22, vcnt 4..9.
    run_to(9, 3);
    chk("pos_row3_inactive", rec_active, 0);
    run_to(8, 4);
    chk("pos_h6_inactive", rec_active, 0);
    tick(1'b0);
    chk("pos_first_act", rec_active, 1);
    chk("pos_first_x", rec_x, 0);
    chk("pos_first_y", rec_y, 0);
    run_to(24, 9);
    chk("pos_last_act", rec_active, 1);
    chk("pos_last_x", rec_x, H_A - 1);
    chk("pos_last_y", rec_y, V_A - 1);
    tick(1'b0);
    chk("pos_past_act", rec_active, 0);
    chk("pos_past_x", rec_x, 0);

    // Line 5 of the next frame shortened by one tick.
    run_to(H_T - 1, 4);
    chk("short_pre_locked", locked, 1);
    cur_len = H_T - 1;
    run_to(0, 6);
    chk("short_before_locked", locked, 1);
    chk("short_before_err", sync_err, 0);
    tick(1'b0);
    chk("short_locked", locked, 0);
    chk("short_err", sync_err, 1);
    chk("short_linelen", line_len, H_T - 1);
    tick(1'b0);
    run_to(1, 0);
    tick(1'b0);
    run_to(1, 0);
    chk("relock_locked", locked, 1);
    chk("relock_err_sticky", sync_err, 1);
    pulse_clear();
    chk("clear_err", sync_err, 0);
    chk("clear_locked", locked, 1);

    // HS goes dead after line 6; ClearErr is held on the violating tick.
    run_to(H_T - 1, 6);
    hs_dead = 1'b1;
    tick(1'b0);
    chk("dead_pre_locked", locked, 1);
    chk("dead_pre_err", sync_err, 0);
    tick(1'b1);
    chk("dead_err_set_wins", sync_err, 1);
    chk("dead_locked", locked, 0);
    repeat (2100) tick(1'b0);
    chk("dead_linelen", line_len, H_T);
    chk("dead_still_unlocked", locked, 0);
    chk("dead_err", sync_err, 1);
    chk("dead_recact", rec_active, 0);

    // Restore HS; geometry is clean again so it re-locks.
    hs_dead = 1'b0;
    repeat (3) begin
      tick(1'b0);
      run_to(1, 0);
    end
    chk("restore_locked", locked, 1);
    chk("restore_linelen", line_len, H_T);
    pulse_clear();
    chk("restore_clear", sync_err, 0);

    // Asynchronous reset mid-frame while locked.
    run_to(10, 5);
    chk("mid_locked", locked, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    tick(1'b0);
    run_to(1, 0);
    chk("rst_relock_first", locked, 0);
    tick(1'b0);
    run_to(0, 0);
    chk("rst_relock_pre", locked, 0);
    tick(1'b0);
    chk("rst_relock_second", locked, 1);

    // HS one tick narrow from reset: never locks.
    #2 rst = 1'b1;
    gh = 0; gv = 0; lh = -1; lv = -1; cur_len = H_T; hs_w = H_S - 1;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      tick(1'b0);
      run_to(1, 0);
    end
    tick(1'b0);
    chk("narrow_locked", locked, 0);
    chk("narrow_hswidth", hs_width, H_S - 1);
    chk("narrow_err", sync_err, 0);
    chk("narrow_linelen", line_len, H_T);
    chk("narrow_frlines", frame_lines, V_T);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
